// File: rtl/mulu_x6y6_seq_pkg.sv
// Shared constants for the time-shared 6x6 unsigned multiplier: size defaults,
// FSM encoding, step count and the per-step partial-product shift.
package mulu_x6y6_seq_pkg;

  localparam int HALF_DEF = 3;
  localparam int W_DEF    = 6;
  localparam int STEPS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step order is xL*yL, xH*yL, xL*yH, xH*yH, so the weight is HALF per high half.
  function automatic int step_shift(input logic [1:0] step, input int half);
    case (step)
      2'd0:       return 0;
      2'd1, 2'd2: return half;
      default:    return 2 * half;
    endcase
  endfunction

endpackage

// File: rtl/mulu_x6y6_seq_mulu_x3y3.sv
// Combinational NxN multiplier (default 3x3), optionally signed. It always
// completes within the cycle; HAS_READY only gates ready to the request.
module mulu_x3y3 #(
  parameter int N         = 3,
  parameter bit HAS_SIGN  = 1'b0,
  parameter bit HAS_READY = 1'b0
) (
  input  logic [N-1:0]   x_i,
  input  logic [N-1:0]   y_i,
  input  logic           valid_i,
  output logic           ready_o,
  output logic [2*N-1:0] p_o
);

  generate
    if (HAS_SIGN) begin : g_signed
      assign p_o = $signed({{N{x_i[N-1]}}, x_i}) * $signed({{N{y_i[N-1]}}, y_i});
    end else begin : g_unsigned
      assign p_o = {{N{1'b0}}, x_i} * {{N{1'b0}}, y_i};
    end
  endgenerate

  assign ready_o = valid_i | !HAS_READY;

endmodule

// File: rtl/mulu_x6y6_seq.sv
// 6x6 unsigned multiply in four steps through one shared 3x3 multiplier.
// Build option MULU_SEQ_ZERO_SKIP_EN: zero operands finish after one cycle.
module mulu_x6y6_seq
  import mulu_x6y6_seq_pkg::*;
#(
  parameter int HALF = HALF_DEF,
  parameter int W    = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy,
  output logic [1:0]     state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and p is frozen while out_valid.

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d;
  logic [2*W-1:0]   acc_q, acc_d, p_q, p_d;
  logic             out_valid_q;
  logic [HALF-1:0]  x_half, y_half;
  logic [2*HALF-1:0] pp;
  logic [2*W-1:0]   pp_ext, pp_shift;
  logic             mul_ready;
  logic             last_step;

  // Step bit 0 picks the x half, bit 1 the y half.
  assign x_half = step_q[0] ? x_q[W-1:HALF] : x_q[HALF-1:0];
  assign y_half = step_q[1] ? y_q[W-1:HALF] : y_q[HALF-1:0];

  mulu_x3y3 #(
    .N        (HALF),
    .HAS_SIGN (1'b0),
    .HAS_READY(1'b0)
  ) u_mul (
    .x_i    (x_half),
    .y_i    (y_half),
    .valid_i(state_q == ST_MUL),
    .ready_o(mul_ready),
    .p_o    (pp)
  );

  assign pp_ext   = {{(2*W-2*HALF){1'b0}}, pp};
  assign pp_shift = pp_ext << step_shift(step_q, HALF);

`ifdef MULU_SEQ_ZERO_SKIP_EN
  // A zero operand finishes on the first MUL edge so out_valid still follows
  // a registered edge after acceptance.
  logic zero_q, zero_d;
  assign last_step = (step_q == 2'(STEPS - 1)) || zero_q;
`else
  assign last_step = (step_q == 2'(STEPS - 1));
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    p_d     = p_q;
`ifdef MULU_SEQ_ZERO_SKIP_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_MUL;
`ifdef MULU_SEQ_ZERO_SKIP_EN
          zero_d  = (x == '0) || (y == '0);
`endif
        end
      end
      ST_MUL: begin
        if (mul_ready) begin
          acc_d  = acc_q + pp_shift;
          step_d = step_q + 2'd1;
          if (last_step) begin
`ifdef MULU_SEQ_ZERO_SKIP_EN
            p_d = zero_q ? '0 : acc_q + pp_shift;
`else
            p_d = acc_q + pp_shift;
`endif
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MULU_SEQ_ZERO_SKIP_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= (state_d == ST_DONE);
`ifdef MULU_SEQ_ZERO_SKIP_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mulu_x6y6_seq.sv
// Directed bench for mulu_x6y6_seq: scoreboard of expected products plus
// latency, hold, reset-abort and back-to-back spacing steps.
module tb_mulu_x6y6_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  x, y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;
  logic        busy;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];

  mulu_x6y6_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy),
    .state_o  (dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [5:0] xv, input logic [5:0] yv);
`ifdef MULU_SEQ_ZERO_SKIP_EN
    return (xv == 6'd0 || yv == 6'd0) ? 1 : 4;
`else
    return (xv == yv) ? 4 : 4;
`endif
  endfunction

  // Scoreboard: pop one expected product per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("product", p, exp_q.pop_front());
    end
  end

  // ---- driver tasks ----
  task automatic run_op(input logic [5:0] xv, input logic [5:0] yv, input int hold);
    int lat;
    logic [11:0] prod;
    prod = 12'(xv) * 12'(yv);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(prod);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 6'($urandom_range(0, 63));
    y = 6'($urandom_range(0, 63));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat(xv, yv));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      x = 6'($urandom_range(0, 63));
      y = 6'($urandom_range(0, 63));
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_p", p, prod);
      check("hold_in_ready", in_ready, 0);
      check("hold_state", dbg_state, 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_busy", busy, 0);
  endtask

  // ---- directed sequence ----
  initial begin
    int n;
    int acc_cyc[4];
    logic [5:0] bx[4];
    logic [5:0] by[4];
    bx = '{6'd11, 6'd63, 6'd0, 6'd37};
    by = '{6'd13, 6'd62, 6'd9, 6'd21};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(6'd5, 6'd6, 0);
    run_op(6'd63, 6'd63, 0);
    run_op(6'd0, 6'd45, 0);
    run_op(6'd9, 6'd9, 0);
    run_op(6'd7, 6'd56, 5);

    // Reset during step 2 of 40*33: no result may appear.
    @(negedge clk);
    x = 6'd40;
    y = 6'd33;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_p", p, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_hold_valid", out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(6'd2, 6'd3, 0);

    // Back-to-back with both valids held high.
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready_seen", in_ready, 1);
      x = bx[k];
      y = by[k];
      exp_q.push_back(12'(bx[k]) * 12'(by[k]));
      acc_cyc[k] = cyc;
      if (k > 0) check("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], 6);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drained", exp_q.size(), 0);

    // Exhaustive sweep of all operand pairs.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        run_op(6'(i), 6'(j), 0);
      end
    end
    @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
